// File: rtl/rx_cnt_pkg.sv
// rx_cnt_pkg: shared state encoding and default geometry for the RX bit/frame counter.
// Contents:
//   state_t      - FSM states IDLE / COUNT / DONE
//   NUM_BITS_DEF - default bits per frame
//   OVS_DEF      - default sample ticks per bit
package rx_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    localparam int NUM_BITS_DEF = 10;
    localparam int OVS_DEF      = 16;

endpackage

// File: rtl/rx_sample_div.sv
// rx_sample_div: sample-tick divider that marks the bit centre and the end of each bit period.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   tick         - count enable; the counter advances only when high
//   clr          - synchronous clear to zero, dominates tick
//   mid          - combinational: this tick lands on the bit centre (cnt == OVS/2-1)
//   wrap         - combinational: this tick ends the bit period (cnt == OVS-1)
module rx_sample_div #(
    parameter int OVS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clr,
    output logic mid,
    output logic wrap
);

    localparam int W = $clog2(OVS);

    logic [W-1:0] cnt_q, cnt_d;

    assign mid  = tick && cnt_q == W'(OVS / 2 - 1);
    assign wrap = tick && cnt_q == W'(OVS - 1);

    always_comb cnt_d = (clr || wrap) ? '0 : tick ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

endmodule

// File: rtl/rx_bit_frame_counter.sv
// rx_bit_frame_counter: oversampled RX bit/frame timing FSM with registered strobes.
// Parameters: NUM_BITS (bits per frame, 2..32), OVS (ticks per bit, even, 4..64).
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   clear        - synchronous abort back to IDLE, dominates start and tick
//   start        - one-cycle frame start request
//   tick         - sample-rate enable
//   busy         - high while in COUNT or DONE
//   mid_strb     - one-cycle pulse at each bit centre
//   bit_done     - one-cycle pulse at the end of each bit
//   frame_done   - one-cycle pulse after the last bit of a frame
//   bit_idx      - current bit index, 0-based
//   overrun      - only with RX_CNT_OVERRUN_EN: sticky flag for start seen during COUNT
// Build option: define RX_CNT_OVERRUN_EN to add the overrun output.
module rx_bit_frame_counter
    import rx_cnt_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int OVS      = OVS_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        start,
    input  logic                        tick,
    output logic                        busy,
    output logic                        mid_strb,
    output logic                        bit_done,
    output logic                        frame_done,
    output logic [$clog2(NUM_BITS)-1:0] bit_idx
`ifdef RX_CNT_OVERRUN_EN
    ,
    output logic                        overrun
`endif
);

    localparam int BW = $clog2(NUM_BITS);

    state_t        state_q;
    logic          busy_q, mid_q, bd_q, fd_q;
    logic [BW-1:0] idx_q;
    logic          counting, last_bit, div_mid, div_wrap;

    assign counting = state_q == COUNT;
    assign last_bit = idx_q == BW'(NUM_BITS - 1);

    // The divider only sees ticks while counting; leaving COUNT or aborting zeroes it.
    rx_sample_div #(.OVS(OVS)) u_div (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick && counting && !clear),
        .clr    (clear || !counting),
        .mid    (div_mid),
        .wrap   (div_wrap)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            mid_q   <= 1'b0;
            bd_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            mid_q   <= 1'b0;
            bd_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            mid_q <= div_mid;
            bd_q  <= div_wrap;
            // frame_done trails the single DONE cycle by one clock.
            fd_q  <= state_q == DONE;
            case (state_q)
                IDLE:
                    if (start) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                COUNT:
                    if (div_wrap) begin
                        if (last_bit) state_q <= DONE;
                        else          idx_q   <= idx_q + BW'(1);
                    end
                DONE: begin
                    state_q <= start ? COUNT : IDLE;
                    busy_q  <= start;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end

    assign busy       = busy_q;
    assign mid_strb   = mid_q;
    assign bit_done   = bd_q;
    assign frame_done = fd_q;
    assign bit_idx    = idx_q;

`ifdef RX_CNT_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)                 ovr_q <= 1'b0;
        else if (clear)               ovr_q <= 1'b0;
        else if (counting && start)   ovr_q <= 1'b1;

    assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_rx_bit_frame_counter.sv
// tb_rx_bit_frame_counter: directed self-checking bench for rx_bit_frame_counter (NUM_BITS=10, OVS=16).
module tb_rx_bit_frame_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       busy, mid_strb, bit_done, frame_done;
    logic [3:0] bit_idx;
`ifdef RX_CNT_OVERRUN_EN
    logic       overrun;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rx_bit_frame_counter #(.NUM_BITS(10), .OVS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .start     (start),
        .tick      (tick),
        .busy      (busy),
        .mid_strb  (mid_strb),
        .bit_done  (bit_done),
        .frame_done(frame_done),
        .bit_idx   (bit_idx)
`ifdef RX_CNT_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        n_chk++;
        if ({busy, mid_strb, bit_done, frame_done, bit_idx} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=00000000", {busy, mid_strb, bit_done, frame_done, bit_idx});
        end
        step;
        step;
        reset_n = 1'b1;
        tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step;
            n_chk++;
            if ({busy, mid_strb, bit_done, frame_done, bit_idx} !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_ignores_tick cycle=%0d got=%b exp=00000000", c, {busy, mid_strb, bit_done, frame_done, bit_idx});
            end
        end
        tick = 1'b0;
    endtask

    // Full frame from IDLE; alt=1 ticks only on odd cycles, doubling every interval.
    task automatic test_frame(input bit alt);
        int p, d, fd, e_idx;
        logic e_mid, e_bd;
        p  = alt ? 32 : 16;
        d  = alt ? 0 : 1;
        fd = p + d + 9 * p + 1;
        start = 1'b1;
        tick  = !alt;
        step;
        start = 1'b0;
        for (int c = 1; c <= fd + 20; c++) begin
            e_mid = c >= p / 2 + d && c < fd && (c - p / 2 - d) % p == 0;
            e_bd  = c >= p + d && c < fd && (c - p - d) % p == 0;
            e_idx = (c >= fd || c < p + d) ? 0 : ((c - p - d) / p + 1 > 9 ? 9 : (c - p - d) / p + 1);
            n_chk++;
            if (mid_strb !== e_mid) begin
                n_fail++;
                $display("FAIL frame%0d_mid cycle=%0d got=%b exp=%b", alt, c, mid_strb, e_mid);
            end
            n_chk++;
            if (bit_done !== e_bd) begin
                n_fail++;
                $display("FAIL frame%0d_bit_done cycle=%0d got=%b exp=%b", alt, c, bit_done, e_bd);
            end
            n_chk++;
            if (frame_done !== (c == fd)) begin
                n_fail++;
                $display("FAIL frame%0d_frame_done cycle=%0d got=%b exp=%b", alt, c, frame_done, c == fd);
            end
            n_chk++;
            if (busy !== (c < fd)) begin
                n_fail++;
                $display("FAIL frame%0d_busy cycle=%0d got=%b exp=%b", alt, c, busy, c < fd);
            end
            n_chk++;
            if (bit_idx !== 4'(e_idx)) begin
                n_fail++;
                $display("FAIL frame%0d_bit_idx cycle=%0d got=%0d exp=%0d", alt, c, bit_idx, e_idx);
            end
            tick = alt ? (c % 2 == 1) : 1'b1;
            step;
        end
        tick = 1'b0;
    endtask

    task automatic test_clear;
        start = 1'b1;
        tick  = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c < 72; c++) step;
        n_chk++;
        if (bit_idx !== 4'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre got idx=%0d busy=%b exp idx=4 busy=1", bit_idx, busy);
        end
        clear = 1'b1;
        start = 1'b1;
        step;
        clear = 1'b0;
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || bit_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_next got busy=%b idx=%0d exp busy=0 idx=0", busy, bit_idx);
        end
        for (int c = 0; c < 40; c++) begin
            n_chk++;
            if ({busy, mid_strb, bit_done, frame_done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL clear_quiet cycle=%0d got=%b exp=0000", c, {busy, mid_strb, bit_done, frame_done});
            end
            step;
        end
        tick = 1'b0;
        test_frame(1'b0);
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        tick  = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c < 161; c++) begin
            start = (c == 50);
            n_chk++;
            if (frame_done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first cycle=%0d got fd=%b busy=%b exp fd=0 busy=1", c, frame_done, busy);
            end
            step;
        end
        n_chk++;
        if (bit_idx !== 4'd9 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_cycle got idx=%0d busy=%b exp idx=9 busy=1", bit_idx, busy);
        end
        start = 1'b1;
        step;
        start = 1'b0;
        n_chk++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || bit_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_restart got fd=%b busy=%b idx=%0d exp fd=1 busy=1 idx=0", frame_done, busy, bit_idx);
        end
        for (int c = 163; c <= 340; c++) begin
            step;
            n_chk++;
            if (frame_done !== (c == 323) || busy !== (c < 323) || mid_strb !== (c >= 170 && c < 323 && (c - 170) % 16 == 0)) begin
                n_fail++;
                $display("FAIL b2b_second cycle=%0d got fd=%b busy=%b mid=%b", c, frame_done, busy, mid_strb);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_async_reset;
        start = 1'b1;
        tick  = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c < 40; c++) step;
        n_chk++;
        if (busy !== 1'b1 || bit_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL areset_pre got busy=%b idx=%0d exp busy=1 idx=2", busy, bit_idx);
        end
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, mid_strb, bit_done, frame_done, bit_idx} !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_immediate got=%b exp=00000000", {busy, mid_strb, bit_done, frame_done, bit_idx});
        end
        step;
        reset_n = 1'b1;
        tick = 1'b0;
        step;
        test_frame(1'b0);
    endtask

`ifdef RX_CNT_OVERRUN_EN
    task automatic test_overrun;
        start = 1'b1;
        tick  = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            start = (c == 55);
            if (c == 56) begin
                n_chk++;
                if (overrun !== 1'b1 || bit_idx !== 4'd3) begin
                    n_fail++;
                    $display("FAIL overrun_set got ovr=%b idx=%0d exp ovr=1 idx=3", overrun, bit_idx);
                end
            end
            if (c == 162) begin
                n_chk++;
                if (frame_done !== 1'b1 || overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_frame got fd=%b ovr=%b exp fd=1 ovr=1", frame_done, overrun);
                end
            end
            step;
        end
        clear = 1'b1;
        step;
        clear = 1'b0;
        n_chk++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear got=%b exp=0", overrun);
        end
        tick = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_frame(1'b0);
        test_frame(1'b1);
        test_clear;
        test_back_to_back;
        test_async_reset;
`ifdef RX_CNT_OVERRUN_EN
        test_overrun;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
